instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction-fetch stage that consumes the program-counter value and produces instructions for decode. It owns the fetch PC, drives a synchronous instruction memory with 1-cycle read latency, and buffers returned words in a small FIFO. It delivers {instruction, pc} pairs to decode over a valid/ready handshake. It supports halt (freeze issue) and redirect (branch/jump target, flushes everything in flight).

Parameters:
ADDR_W, 10, imem word-address width (imem holds 2^ADDR_W 32-bit words)
RESET_PC, 32'h0000_0000, fetch PC value loaded on reset
FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2)

Ports:
clk  input  1  single clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
halt  input  1  1 = issue no new fetches; buffered/in-flight words still drain
redirect_valid  input  1  1 = load fetch PC from redirect_pc and flush
redirect_pc  input  32  redirect target byte address
imem_en  output  1  imem read strobe
imem_addr  output  ADDR_W  imem word address = fetch_pc[ADDR_W+1:2]
imem_rdata  input  32  read data, valid the cycle after imem_en
inst_valid  output  1  FIFO head valid
inst_ready  input  1  decode accepts head
inst_out  output  32  instruction at FIFO head
inst_pc  output  32  byte PC of inst_out
fetch_pc  output  32  next PC to be issued
halted  output  1  halt=1 and no read in flight

Behaviour:
- Reset (rst=1 at posedge): fetch_pc=RESET_PC, FIFO empty, in-flight flag 0, inst_valid=0, inst_out=0, inst_pc=0, halted=0. imem_en is combinational and forced 0 while rst=1. Reset mid-operation discards all buffered and in-flight data.
- Issue condition (combinational): !rst & !halt & !redirect_valid & (count + inflight - pop < FIFO_DEPTH), where pop = inst_valid & inst_ready. When it holds: imem_en=1, and at the edge fetch_pc <= fetch_pc + 4, inflight <= 1, inflight_pc <= fetch_pc. Otherwise imem_en=0 and inflight <= 0.
- Response: if inflight=1 and no redirect this cycle, push {imem_rdata, inflight_pc} into the FIFO at the edge.
- Latency: issue in cycle N -> rdata in N+1 -> inst_valid in N+2. With inst_ready held at 1, throughput is 1 instruction/cycle after the first.
- Handshake: inst_out/inst_pc stay stable while inst_valid=1 and inst_ready=0. A pop advances the head. Push and pop in the same cycle are legal at any occupancy, and the credit rule guarantees no overflow. inst_ready is ignored when the FIFO is empty.
- Redirect: takes priority over halt and issue. At the edge: fetch_pc <= {redirect_pc[31:2], 2'b00} (misaligned low bits are dropped), FIFO flushed, in-flight response discarded, no push, no pop. inst_valid=0 the cycle after. The first fetch from the target issues the cycle after redirect.
- Halt: issue stops the same cycle. An outstanding read still lands in the FIFO, and the FIFO keeps draining. halted=1 once inflight=0. Deasserting halt resumes issue from fetch_pc with no skipped or duplicated PC.
- Wrap: fetch_pc wraps modulo 2^32. imem_addr wraps at 4*2^ADDR_W bytes, using the low bits only.

Decomposition:
- Shared package/header kgp_fetch_pkg: INSTR_W=32, PC_INC=4, RESET_PC default, fetch entry width (INSTR_W+32).
- One sub-module: fetch_fifo. It is a synchronous FIFO parameterised by width and depth, with push, pop, flush and count, and flush has priority over push.
- The top level holds fetch_pc, the in-flight flag/PC and the credit logic.

Test Plan:
- Reset then inst_ready=1, imem returns word=addr*4+0xA000 -> inst_valid first at cycle 2; inst_pc sequence 0,4,8,12 on consecutive cycles; inst_out matches.
- inst_ready=0 for 5 cycles after streaming -> FIFO holds exactly FIFO_DEPTH entries, imem_en=0 while full, head stable; release -> no loss or duplicate.
- redirect_valid=1 with redirect_pc=0x0000_0103 while FIFO full and read in flight -> next cycle inst_valid=0, fetch_pc=0x100; first delivered inst_pc=0x100; no stale PC ever appears.
- halt=1 for 4 cycles mid-stream -> imem_en=0 the same cycle; halted=1 one cycle later; delivered PCs stay contiguous across resume.
- RESET_PC=0xFFFF_FFF8, stream 4 instructions -> inst_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4; imem_addr wraps correctly.
- rst=1 for 1 cycle with FIFO non-empty and read in flight -> next cycle inst_valid=0, fetch_pc=RESET_PC; the old in-flight word is never delivered.

Source files
------------

// File: rtl/kgp_fetch_pkg.sv
// Shared constants and the buffered fetch-entry layout for the instruction-fetch stage.
package kgp_fetch_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned ENTRY_W          = INSTR_W + 32;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/flush and occupancy count; flush beats push and pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;

  // Empty head reads as zero so the consumer never sees stale storage.
  always_comb begin
    valid  = (count != '0);
    do_pop = pop && valid;
    dout   = valid ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues 1-cycle-latency imem reads under a credit limit,
// and buffers returned words for decode behind a valid/ready handshake.
module instr_fetch_unit
  import kgp_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               halt,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INSTR_W-1:0] inst_out,
  output logic [31:0]        inst_pc,
  output logic [31:0]        fetch_pc,
  output logic               halted
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  logic          inflight;
  logic [31:0]   inflight_pc;
  logic [CW-1:0] count;
  logic [OW-1:0] occ;
  logic          pop;
  logic          push;
  logic          issue;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;
  logic          redirect_lsb_unused;

  // Credit counts buffered words plus the outstanding read, minus the word leaving this cycle.
  always_comb begin
    pop        = inst_valid && inst_ready;
    occ        = OW'(count) + OW'(inflight) - OW'(pop);
    issue      = !rst && !halt && !redirect_valid && (occ < OW'(FIFO_DEPTH));
    push       = inflight && !redirect_valid;
    push_entry = '{instr: imem_rdata, pc: inflight_pc};
  end

  assign imem_en             = issue;
  assign imem_addr           = fetch_pc[ADDR_W+1:2];
  assign inst_out            = head_entry.instr;
  assign inst_pc             = head_entry.pc;
  assign halted              = halt && !inflight && !rst;
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
    end else if (issue) begin
      fetch_pc    <= fetch_pc + PC_INC;
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head_entry),
    .valid (inst_valid),
    .count (count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected PCs are queued as streams are started
// and popped whenever decode accepts an instruction.
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, halt, redirect_valid, inst_ready;
  logic [31:0]       redirect_pc;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata = '0;
  logic              inst_valid, halted;
  logic [31:0]       inst_out, inst_pc, fetch_pc;

  logic              w_rst, w_ready, w_en, w_valid, w_halted;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_rdata = '0;
  logic [31:0]       w_out, w_pc, w_fetch_pc;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] tail_pc;
  logic [31:0] e;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .halt(halt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
    .fetch_pc(fetch_pc), .halted(halted));

  instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
    .clk(clk), .rst(w_rst), .halt(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_en(w_en), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .inst_valid(w_valid), .inst_ready(w_ready), .inst_out(w_out), .inst_pc(w_pc),
    .fetch_pc(w_fetch_pc), .halted(w_halted));

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'({a, 2'b00}) + 32'hA000;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return 32'({pc[ADDR_W+1:2], 2'b00}) + 32'hA000;
  endfunction

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
    if (w_en)    w_rdata    <= mem_word(w_addr);
  end

  task automatic test_reset();
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    w_rst = 1'b1; w_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL reset_imem_en: got %b expected 0", imem_en); end
    n_checks++; if (inst_valid !== 1'b0 || inst_out !== '0 || inst_pc !== '0) begin
      n_fail++; $display("FAIL reset_head: got valid %b inst %h pc %h expected 0 0 0", inst_valid, inst_out, inst_pc); end
    n_checks++; if (fetch_pc !== 32'h0) begin n_fail++; $display("FAIL reset_fetch_pc: got %h expected 00000000", fetch_pc); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
  endtask

  task automatic test_stream();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    tail_pc = 32'd16;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin rst = 1'b0; inst_ready = 1'b1; end
      #1;
      if (k == 0) begin n_checks++; if (imem_en !== 1'b1 || imem_addr !== '0) begin
        n_fail++; $display("FAIL stream_first_issue: got en %b addr %h expected 1 000", imem_en, imem_addr); end end
      n_checks++;
      if (inst_valid !== (k >= 2)) begin n_fail++; $display("FAIL stream_valid_c%0d: got %b expected %b", k, inst_valid, k >= 2); end
      if (inst_valid && inst_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL stream_extra: got pc %h expected no delivery", inst_pc); end
        else begin
          e = exp_q.pop_front();
          if (inst_pc !== e || inst_out !== word_of(e)) begin n_fail++;
            $display("FAIL stream_data: got pc %h inst %h expected pc %h inst %h", inst_pc, inst_out, e, word_of(e)); end
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stream_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) inst_ready = 1'b0;
      #1;
      n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL bp_imem_en_c%0d: got %b expected 0", k, imem_en); end
      n_checks++; if (inst_valid !== 1'b1 || inst_pc !== tail_pc || inst_out !== word_of(tail_pc)) begin
        n_fail++; $display("FAIL bp_head_stable_c%0d: got valid %b pc %h expected 1 %h", k, inst_valid, inst_pc, tail_pc); end
    end
    for (int i = 0; i < 6; i++) exp_q.push_back(tail_pc + 32'(i * 4));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) inst_ready = 1'b1;
      #1;
      if (k == 0) begin n_checks++; if (imem_en !== 1'b1 || fetch_pc !== tail_pc + 32'd8) begin
        n_fail++; $display("FAIL bp_resume_issue: got en %b fetch_pc %h expected 1 %h", imem_en, fetch_pc, tail_pc + 32'd8); end end
      n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release_valid_c%0d: got 0 expected 1", k); end
      if (inst_valid && inst_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_extra: got pc %h expected no delivery", inst_pc); end
        else begin
          e = exp_q.pop_front();
          if (inst_pc !== e || inst_out !== word_of(e)) begin n_fail++;
            $display("FAIL bp_data: got pc %h inst %h expected pc %h inst %h", inst_pc, inst_out, e, word_of(e)); end
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d pending expected 0", exp_q.size()); end
    tail_pc = tail_pc + 32'd24;
  endtask

  task automatic test_redirect();
    @(negedge clk);
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL redir_no_issue: got %b expected 0", imem_en); end
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1; end
      #1;
      if (k == 0) begin
        n_checks++; if (fetch_pc !== 32'h100) begin n_fail++; $display("FAIL redir_fetch_pc: got %h expected 00000100", fetch_pc); end
        n_checks++; if (imem_en !== 1'b1 || imem_addr !== 10'h040) begin
          n_fail++; $display("FAIL redir_first_issue: got en %b addr %h expected 1 040", imem_en, imem_addr); end
      end
      n_checks++;
      if (inst_valid !== (k >= 2)) begin n_fail++; $display("FAIL redir_valid_c%0d: got %b expected %b", k, inst_valid, k >= 2); end
      if (inst_valid && inst_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL redir_extra: got pc %h expected no delivery", inst_pc); end
        else begin
          e = exp_q.pop_front();
          if (inst_pc !== e || inst_out !== word_of(e)) begin n_fail++;
            $display("FAIL redir_data: got pc %h inst %h expected pc %h inst %h", inst_pc, inst_out, e, word_of(e)); end
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL redir_drain: got %0d pending expected 0", exp_q.size()); end
    tail_pc = 32'h118;
  endtask

  task automatic test_halt();
    for (int i = 0; i < 6; i++) exp_q.push_back(tail_pc + 32'(i * 4));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) halt = 1'b1;
      if (k == 4) halt = 1'b0;
      #1;
      if (k < 4) begin n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL halt_imem_en_c%0d: got %b expected 0", k, imem_en); end end
      if (k < 4) begin n_checks++; if (halted !== (k >= 1)) begin
        n_fail++; $display("FAIL halt_halted_c%0d: got %b expected %b", k, halted, k >= 1); end end
      if (k == 4) begin n_checks++; if (imem_en !== 1'b1 || imem_addr !== 10'h048 || halted !== 1'b0) begin
        n_fail++; $display("FAIL halt_resume: got en %b addr %h halted %b expected 1 048 0", imem_en, imem_addr, halted); end end
      if (inst_valid && inst_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL halt_extra: got pc %h expected no delivery", inst_pc); end
        else begin
          e = exp_q.pop_front();
          if (inst_pc !== e || inst_out !== word_of(e)) begin n_fail++;
            $display("FAIL halt_data: got pc %h inst %h expected pc %h inst %h", inst_pc, inst_out, e, word_of(e)); end
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL halt_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rst = 1'b1; inst_ready = 1'b0;
    #1;
    n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL rmid_imem_en: got %b expected 0", imem_en); end
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin rst = 1'b0; inst_ready = 1'b1; end
      #1;
      if (k == 0) begin n_checks++; if (inst_valid !== 1'b0 || fetch_pc !== 32'h0 || imem_addr !== '0) begin
        n_fail++; $display("FAIL rmid_state: got valid %b fetch_pc %h addr %h expected 0 00000000 000", inst_valid, fetch_pc, imem_addr); end end
      if (inst_valid && inst_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rmid_extra: got pc %h expected no delivery", inst_pc); end
        else begin
          e = exp_q.pop_front();
          if (inst_pc !== e || inst_out !== word_of(e)) begin n_fail++;
            $display("FAIL rmid_data: got pc %h inst %h expected pc %h inst %h", inst_pc, inst_out, e, word_of(e)); end
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rmid_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_addr [3];
    exp_addr[0] = 10'h3FE; exp_addr[1] = 10'h3FF; exp_addr[2] = 10'h000;
    exp_q.delete();
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000); exp_q.push_back(32'h0000_0004);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin w_rst = 1'b0; w_ready = 1'b1; end
      #1;
      if (k == 0) begin n_checks++; if (w_fetch_pc !== 32'hFFFF_FFF8) begin
        n_fail++; $display("FAIL wrap_reset_pc: got %h expected fffffff8", w_fetch_pc); end end
      if (k < 3) begin n_checks++; if (w_en !== 1'b1 || w_addr !== exp_addr[k]) begin
        n_fail++; $display("FAIL wrap_addr_c%0d: got en %b addr %h expected 1 %h", k, w_en, w_addr, exp_addr[k]); end end
      if (w_valid && w_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL wrap_extra: got pc %h expected no delivery", w_pc); end
        else begin
          e = exp_q.pop_front();
          if (w_pc !== e || w_out !== word_of(e)) begin n_fail++;
            $display("FAIL wrap_data: got pc %h inst %h expected pc %h inst %h", w_pc, w_out, e, word_of(e)); end
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
